// File: rtl/pulse_width_decoder_pkg.sv
// Shared types and the width classifier for the stretched-pulse decoder.
package pulse_dec_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_SHORT = 2'd0,
    CLS_MATCH = 2'd1,
    CLS_LONG  = 2'd2
  } class_t;

  localparam logic [7:0] STAT_MAX = 8'd255;

  // Callers zero-extend W-bit values; expected - tol never underflows by construction.
  function automatic class_t classify(input logic [15:0] width,
                                      input logic [15:0] expected,
                                      input logic [15:0] tol);
    class_t cls;
    if (width < (expected - tol)) begin
      cls = CLS_SHORT;
    end else if (width > (expected + tol)) begin
      cls = CLS_LONG;
    end else begin
      cls = CLS_MATCH;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pulse_width_decoder_if.sv
// Pulse input, clear and decoded event/status bundle of the pulse width decoder.
interface pulse_width_decoder_if #(
  parameter int W = 8
);
  logic         in_pulse;
  logic         clear;
  logic         evt_valid;
  logic [W-1:0] evt_width;
  logic         evt_match;
  logic         evt_short;
  logic         evt_long;
  logic         busy;
  logic         err_timeout;
  logic [7:0]   match_count;
  logic [7:0]   error_count;

  modport master (
    output in_pulse, clear,
    input  evt_valid, evt_width, evt_match, evt_short, evt_long,
    input  busy, err_timeout, match_count, error_count
  );

  modport slave (
    input  in_pulse, clear,
    output evt_valid, evt_width, evt_match, evt_short, evt_long,
    output busy, err_timeout, match_count, error_count
  );
endinterface

// File: rtl/pulse_width_decoder_bit_sync.sv
// Single-bit synchronizer chain with a selectable reset level.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pulse_width_decoder.sv
// Measures the high time of each stretched pulse, classifies it and keeps
// sticky timeout plus saturating match/error statistics.
module pulse_width_decoder #(
  parameter int PULSE_CYCLES = 32,
  parameter int TOL          = 2,
  parameter int MAX_CYCLES   = 255,
  parameter int SYNC_STAGES  = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  pulse_width_decoder_if.slave  bus
);
  import pulse_dec_pkg::*;

  localparam int           W     = $clog2(MAX_CYCLES + 1);
  localparam logic [W-1:0] MAX_W = W'(MAX_CYCLES);

  logic         in_s;
  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         evt_d, timeout_d;
  logic [W-1:0] width_d;
  class_t       cls_d;

  logic         evt_valid_q, evt_match_q, evt_short_q, evt_long_q, busy_q;
  logic [W-1:0] evt_width_q;
  logic         err_timeout_q, err_timeout_d;
  logic [7:0]   match_count_q, match_count_d, error_count_q, error_count_d;
  logic [7:0]   match_base_s, error_base_s;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (bus.in_pulse),
        .q_o  (in_s)
      );
    end else begin : g_nosync
      assign in_s = bus.in_pulse;
    end
  endgenerate

  // Pulse measurement FSM: next state, counter and event decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    evt_d     = 1'b0;
    timeout_d = 1'b0;
    width_d   = evt_width_q;
    cls_d     = CLS_MATCH;
    case (state_q)
      WAIT_LOW: begin
        if (!in_s) state_d = IDLE;
        else       state_d = WAIT_LOW;
      end
      IDLE: begin
        if (in_s) begin
          state_d = HIGH;
          cnt_d   = W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (in_s) begin
          if (cnt_q < MAX_W) begin
            cnt_d = cnt_q + W'(1);
          end else begin
            // Stuck high: report once, then ignore the rest of this pulse.
            evt_d     = 1'b1;
            timeout_d = 1'b1;
            width_d   = MAX_W;
            cls_d     = CLS_LONG;
            state_d   = WAIT_LOW;
          end
        end else begin
          evt_d   = 1'b1;
          width_d = cnt_q;
          cls_d   = classify(16'(cnt_q), 16'(PULSE_CYCLES), 16'(TOL));
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  // Statistics: clear takes effect first, then the same-edge event is counted.
  always_comb begin
    match_base_s  = bus.clear ? 8'd0 : match_count_q;
    error_base_s  = bus.clear ? 8'd0 : error_count_q;
    match_count_d = match_base_s;
    error_count_d = error_base_s;
    err_timeout_d = (bus.clear ? 1'b0 : err_timeout_q) | timeout_d;
    if (evt_d && (cls_d == CLS_MATCH)) begin
      if (match_base_s != STAT_MAX) match_count_d = match_base_s + 8'd1;
      else                          match_count_d = match_base_s;
    end else if (evt_d) begin
      if (error_base_s != STAT_MAX) error_count_d = error_base_s + 8'd1;
      else                          error_count_d = error_base_s;
    end else begin
      match_count_d = match_base_s;
    end
  end

  // State, measurement and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= WAIT_LOW;
      cnt_q         <= '0;
      evt_valid_q   <= 1'b0;
      evt_width_q   <= '0;
      evt_match_q   <= 1'b0;
      evt_short_q   <= 1'b0;
      evt_long_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      match_count_q <= 8'd0;
      error_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      evt_valid_q   <= evt_d;
      evt_width_q   <= width_d;
      evt_match_q   <= evt_d && (cls_d == CLS_MATCH);
      evt_short_q   <= evt_d && (cls_d == CLS_SHORT);
      evt_long_q    <= evt_d && (cls_d == CLS_LONG);
      busy_q        <= (state_d == HIGH);
      err_timeout_q <= err_timeout_d;
      match_count_q <= match_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_width   = evt_width_q;
  assign bus.evt_match   = evt_match_q;
  assign bus.evt_short   = evt_short_q;
  assign bus.evt_long    = evt_long_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.match_count = match_count_q;
  assign bus.error_count = error_count_q;
endmodule

// File: tb/tb_pulse_width_decoder.sv
// Directed plus randomized pulse trains checked against a pulse-level model.
module tb_pulse_width_decoder;
  localparam int PC   = 32;
  localparam int TL   = 2;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pulse_width_decoder_if #(.W(8)) bus ();

  pulse_width_decoder #(
    .PULSE_CYCLES (PC),
    .TOL          (TL),
    .MAX_CYCLES   (MAXC),
    .SYNC_STAGES  (0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errs   = 0;
  int checks = 0;

  // Pulse-level reference state
  int m_match = 0;
  int m_err   = 0;
  int m_to    = 0;
  int m_width = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 0 short, 1 match, 2 long
  function automatic int cls_of(input int w);
    if (w < PC - TL) return 0;
    if (w > PC + TL) return 2;
    return 1;
  endfunction

  task automatic check_stats();
    chk("match_count", 32'(bus.match_count), 32'(m_match));
    chk("error_count", 32'(bus.error_count), 32'(m_err));
    chk("err_timeout", 32'(bus.err_timeout), 32'(m_to));
  endtask

  task automatic check_event(input int w, input int c);
    chk("evt_valid", 32'(bus.evt_valid), 32'd1);
    chk("evt_width", 32'(bus.evt_width), 32'(w));
    chk("evt_match", 32'(bus.evt_match), 32'(c == 1));
    chk("evt_short", 32'(bus.evt_short), 32'(c == 0));
    chk("evt_long",  32'(bus.evt_long),  32'(c == 2));
    chk("busy_evt",  32'(bus.busy), 32'd0);
    check_stats();
  endtask

  task automatic check_idle(input int busy_exp);
    chk("evt_valid_idle", 32'(bus.evt_valid), 32'd0);
    chk("evt_flags_idle", 32'({bus.evt_match, bus.evt_short, bus.evt_long}), 32'd0);
    chk("evt_width_hold", 32'(bus.evt_width), 32'(m_width));
    chk("busy", 32'(bus.busy), 32'(busy_exp));
    check_stats();
  endtask

  task automatic record(input int c, input int is_to);
    if (c == 1) m_match = (m_match < 255) ? m_match + 1 : 255;
    else        m_err   = (m_err   < 255) ? m_err + 1   : 255;
    if (is_to != 0) m_to = 1;
  endtask

  // One pulse of hi high samples followed by lo low samples; clr pulses clear on the fall edge.
  task automatic pulse(input int hi, input int lo, input bit clr);
    int c;
    for (int k = 1; k <= hi; k++) begin
      bus.in_pulse = 1'b1;
      @(posedge clk); #1;
      if (k == MAXC + 1) begin
        m_width = MAXC;
        record(2, 1);
        check_event(MAXC, 2);
      end else begin
        check_idle((k <= MAXC) ? 1 : 0);
      end
    end
    for (int j = 1; j <= lo; j++) begin
      bus.in_pulse = 1'b0;
      bus.clear    = clr && (j == 1);
      @(posedge clk); #1;
      bus.clear = 1'b0;
      if (clr && j == 1) begin
        m_match = 0;
        m_err   = 0;
        m_to    = 0;
      end
      if (j == 1 && hi <= MAXC) begin
        c = cls_of(hi);
        m_width = hi;
        record(c, 0);
        check_event(hi, c);
      end else begin
        check_idle(0);
      end
    end
  endtask

  task automatic model_reset();
    m_match = 0;
    m_err   = 0;
    m_to    = 0;
    m_width = 0;
  endtask

  initial begin
    int hi, lo;
    bus.in_pulse = 1'b0;
    bus.clear    = 1'b0;
    rstn         = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle(0);
    rstn = 1'b1;
    repeat (2) begin @(posedge clk); #1; check_idle(0); end

    // Nominal pulse, then short/match/match/long around the tolerance edges
    pulse(32, 4, 1'b0);
    pulse(29, 3, 1'b0);
    pulse(30, 3, 1'b0);
    pulse(34, 3, 1'b0);
    pulse(35, 3, 1'b0);
    // Minimal pulse with single low sample, back-to-back
    pulse(1, 1, 1'b0);
    pulse(32, 3, 1'b0);
    // Stuck high, then recovery
    pulse(300, 3, 1'b0);
    pulse(32, 3, 1'b0);
    // Saturation boundary: 255 is a normal long, 256 is a timeout
    pulse(255, 2, 1'b0);
    pulse(256, 2, 1'b0);
    pulse(32, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      hi = (i % 10 == 9) ? int'($urandom_range(250, 270)) : int'($urandom_range(1, 45));
      lo = int'($urandom_range(1, 4));
      pulse(hi, lo, 1'b0);
    end

    // Reset in the 10th cycle of a pulse, released while still high
    bus.in_pulse = 1'b1;
    for (int k = 1; k <= 9; k++) begin @(posedge clk); #1; check_idle(1); end
    rstn = 1'b0;
    model_reset();
    #1;
    check_idle(0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; check_idle(0); end
    bus.in_pulse = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; check_idle(0); end
    pulse(32, 3, 1'b0);

    // Build match_count=5 with a pending timeout, then clear on an event edge
    pulse(300, 3, 1'b0);
    repeat (4) pulse(32, 3, 1'b0);
    chk("match_before_clear", 32'(bus.match_count), 32'd5);
    pulse(32, 3, 1'b1);
    chk("match_after_clear", 32'(bus.match_count), 32'd1);

    // Counter saturation
    repeat (260) pulse(1, 1, 1'b0);
    chk("error_sat", 32'(bus.error_count), 32'd255);
    repeat (256) pulse(32, 1, 1'b0);
    chk("match_sat", 32'(bus.match_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pulse_width_decoder.md
Name: pulse_width_decoder

Overview:
Receive-side decoder for stretched trigger pulses produced by the team's pulse-stretcher counter. Measures the high time of each pulse on in_pulse in clk cycles. Classifies each pulse against the expected width, then reports one single-cycle event per pulse. Keeps sticky error and saturating statistics for status registers.

Parameters:
PULSE_CYCLES, 32, expected pulse width in clk cycles.
TOL, 2, accepted deviation in cycles (±). Constraint: TOL < PULSE_CYCLES.
MAX_CYCLES, 255, measurement saturation / stuck-high timeout. Constraint: PULSE_CYCLES+TOL < MAX_CYCLES.
SYNC_STAGES, 0, synchronizer depth on in_pulse. 0 means in_pulse is already in the clk domain; otherwise ≥2.

Ports:
clk  input  1  clock, rising edge.
rstn  input  1  reset, asynchronous, active-low.
in_pulse  input  1  stretched pulse to decode.
clear  input  1  synchronous clear of sticky flag and statistics.
evt_valid  output  1  one-cycle strobe, one per decoded pulse.
evt_width  output  W  measured width, where W = $clog2(MAX_CYCLES+1). Valid with evt_valid.
evt_match  output  1  width within PULSE_CYCLES±TOL. Qualified by evt_valid.
evt_short  output  1  width < PULSE_CYCLES-TOL.
evt_long  output  1  width > PULSE_CYCLES+TOL, or timeout.
busy  output  1  FSM in HIGH.
err_timeout  output  1  sticky; set when a stuck-high pulse is detected.
match_count  output  8  saturating count of matched events.
error_count  output  8  saturating count of short and long events.

Behaviour:
- in_s is in_pulse after SYNC_STAGES flops. When SYNC_STAGES=0, in_s is in_pulse directly. Synchronizer flops reset to 1.
- All outputs are registered. Reset value of every output and counter is 0. evt_width resets to 0.
- FSM states, reset state WAIT_LOW:
  - WAIT_LOW: on in_s=0 go to IDLE. No measurement happens here. This prevents a partial pulse being measured after reset or after a timeout.
  - IDLE: on in_s=1 go to HIGH with cnt=1.
  - HIGH, in_s=1 and cnt<MAX_CYCLES: cnt+1.
  - HIGH, in_s=1 and cnt==MAX_CYCLES: emit event with width=MAX_CYCLES, evt_long=1, set err_timeout, go to WAIT_LOW.
  - HIGH, in_s=0: emit event with width=cnt, classified, go to IDLE.
- Timing: a pulse sampled high on N consecutive edges gives evt_valid high for exactly the cycle following the edge that first samples low. End-to-end latency from the in_pulse fall is 1+SYNC_STAGES edges.
- On a timeout, the eventual falling edge produces no second event.
- Back-to-back pulses: a single low sample between pulses is sufficient. Each pulse yields its own event.
- When evt_valid=1, exactly one of match/short/long is 1. When evt_valid=0, evt_match/short/long are 0. evt_width holds its last value.
- Classification compares with unsigned arithmetic of width W. There is no underflow, because the parameter constraints guarantee PULSE_CYCLES-TOL ≥ 1.
- Counters saturate at 255 and never wrap.
- clear:
  - Does not affect the FSM, cnt, or evt_* outputs.
  - Zeroes match_count, error_count and err_timeout.
  - If an event or timeout occurs on the same edge, clear is applied first and the event's update follows. The counter becomes 1, and err_timeout is 1 if the event was a timeout.
- Reset mid-pulse: everything is reset to its reset value and the FSM returns to WAIT_LOW. The interrupted pulse produces no event.

Decomposition:
- Package pulse_dec_pkg:
  - enum of state_t {WAIT_LOW, IDLE, HIGH}.
  - enum of class_t {CLS_SHORT, CLS_MATCH, CLS_LONG}.
  - Helper function classify(width, expected, tol) returning class_t.
- Sub-module bit_sync: parameterised depth, parameterised reset value. Instantiated only when SYNC_STAGES>0, via a generate block.
- The FSM, counters and statistics live in the top module.

Test Plan (defaults, SYNC_STAGES=0):
- 32-cycle high pulse after reset and a low period → one evt_valid cycle; evt_width=32, evt_match=1, match_count=1, busy high for the pulse.
- Pulses of 29, 30, 34, 35 cycles, separated by 3 low cycles → classes short, match, match, long; match_count=2, error_count=2.
- 1-cycle pulse, then 1 low cycle, then a 32-cycle pulse → two events: width=1 short, then width=32 match.
- in_pulse held high for 300 cycles → single event width=255, evt_long=1, err_timeout=1; no event on the fall. A following 32-cycle pulse decodes as match.
- rstn asserted on the 10th cycle of a pulse and released while in_pulse is still high → no event for that pulse. The next 32-cycle pulse gives width=32.
- clear asserted on the same edge that registers a matched event, with match_count=5 beforehand → match_count=1, error_count=0, err_timeout=0.
